// File: rtl/spi_cmd_receiver.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_receiver
// Description : SPI mode-0 peripheral front end. Synchronises the SPI pins into
//               sys_clk, deserialises CMD+DATA frames MSB first, and strobes
//               cmd_valid (good frame) or frame_err (wrong bit count).
//               Define SPI_CMD_ECHO_EN to echo the last good frame on spi_miso.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_receiver #(
    parameter int CMD_WIDTH      = 8,
    parameter int DATAWORD_WIDTH = 16,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      spi_sclk,
    input  logic                      spi_cs_n,
    input  logic                      spi_mosi,
    output logic                      spi_miso,
    output logic [CMD_WIDTH-1:0]      cmd_word,
    output logic [DATAWORD_WIDTH-1:0] data_word,
    output logic                      cmd_valid,
    output logic                      frame_err
);

    localparam int c_F     = CMD_WIDTH + DATAWORD_WIDTH;
    localparam int c_CNT_W = $clog2(c_F + 2);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(c_F);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(c_F + 1);

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_SHIFT     = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_hist;
    logic                   r_cs_hist;
    logic                   w_sclk;
    logic                   w_cs;
    logic                   w_mosi;
    logic                   r_sclk_rise;
    logic                   r_cs_rise;
    logic                   r_cs_fall;
    logic                   r_mosi_bit;

    logic [c_F-1:0]     r_shreg;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic               w_clr;
    logic               w_shift;
    logic               w_accept;
    logic               w_reject;

    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    // Chains reset to 0 so a CS held low across reset never looks like a fresh fall.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_hist <= 1'b0;
            r_cs_hist   <= 1'b0;
            r_sclk_rise <= 1'b0;
            r_cs_rise   <= 1'b0;
            r_cs_fall   <= 1'b0;
            r_mosi_bit  <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_sclk_hist <= w_sclk;
            r_cs_hist   <= w_cs;
            r_sclk_rise <= w_sclk & ~r_sclk_hist;
            r_cs_rise   <= w_cs & ~r_cs_hist;
            r_cs_fall   <= ~w_cs & r_cs_hist;
            r_mosi_bit  <= w_mosi;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_WAIT_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clr        = 1'b0;
        w_shift      = 1'b0;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        case (r_state)
            ST_WAIT_IDLE: begin
                if (w_cs) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (r_cs_fall) begin
                    w_state_next = ST_SHIFT;
                    w_clr        = 1'b1;
                end
            end
            ST_SHIFT: begin
                // CS rise takes priority; a coincident SCLK rise is not counted.
                if (r_cs_rise) begin
                    w_state_next = ST_IDLE;
                    if (r_bit_cnt == c_CNT_FULL) begin
                        w_accept = 1'b1;
                    end else begin
                        w_reject = 1'b1;
                    end
                end else if (r_sclk_rise) begin
                    w_shift = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_WAIT_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            cmd_word  <= '0;
            data_word <= '0;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cmd_valid <= w_accept;
            frame_err <= w_reject;
            if (w_clr) begin
                r_bit_cnt <= '0;
            end
            if (w_shift) begin
                r_shreg <= {r_shreg[c_F-2:0], r_mosi_bit};
                if (r_bit_cnt != c_CNT_SAT) begin
                    r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                end
            end
            if (w_accept) begin
                cmd_word  <= r_shreg[c_F-1:DATAWORD_WIDTH];
                data_word <= r_shreg[DATAWORD_WIDTH-1:0];
            end
        end
    end

`ifdef SPI_CMD_ECHO_EN
    logic           r_sclk_fall;
    logic [c_F-1:0] r_echo;
    logic [c_F-1:0] r_miso_sh;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sclk_fall <= 1'b0;
            r_echo      <= '0;
            r_miso_sh   <= '0;
        end else begin
            r_sclk_fall <= ~w_sclk & r_sclk_hist;
            if (w_accept) begin
                r_echo <= r_shreg;
            end
            if (r_state == ST_IDLE && r_cs_fall) begin
                r_miso_sh <= r_echo;
            end else if (r_state == ST_SHIFT && !r_cs_rise && r_sclk_fall) begin
                r_miso_sh <= {r_miso_sh[c_F-2:0], 1'b0};
            end
        end
    end

    assign spi_miso = r_miso_sh[c_F-1] & ~w_cs & (r_state == ST_SHIFT);
`else
    assign spi_miso = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_cmd_receiver
// Description : Scoreboard bench for spi_cmd_receiver; honours SPI_CMD_ECHO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_receiver;

    localparam int c_SYNC = 2;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic [7:0]  cmd_word;
    logic [15:0] data_word;
    logic        cmd_valid;
    logic        frame_err;

    spi_cmd_receiver #(
        .CMD_WIDTH      (8),
        .DATAWORD_WIDTH (16),
        .SYNC_STAGES    (c_SYNC)
    ) u_dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .spi_sclk  (spi_sclk),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .cmd_word  (cmd_word),
        .data_word (data_word),
        .cmd_valid (cmd_valid),
        .frame_err (frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic        err;
        logic [7:0]  cmd;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_valid_seen = 0;
    int          n_err_seen   = 0;
    logic [7:0]  mdl_cmd  = 8'h00;
    logic [15:0] mdl_data = 16'h0000;
    logic        prev_strobe = 1'b0;
    logic [23:0] miso_cap = 24'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per strobe and checks the presented frame.
    always @(negedge sys_clk) begin
        exp_t e;
        if (sys_rst) begin
            mdl_cmd     = 8'h00;
            mdl_data    = 16'h0000;
            prev_strobe = 1'b0;
        end else begin
            if (cmd_valid || frame_err) begin
                chk("strobe_exclusive", {31'd0, cmd_valid & frame_err}, 32'd0);
                chk("strobe_single_cycle", {31'd0, prev_strobe}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got valid=%0b err=%0b, expected none",
                             cmd_valid, frame_err);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_kind_err", {31'd0, frame_err}, {31'd0, e.err});
                    if (!e.err) begin
                        mdl_cmd  = e.cmd;
                        mdl_data = e.data;
                        n_valid_seen++;
                    end else begin
                        n_err_seen++;
                    end
                    chk("cmd_word", {24'd0, cmd_word}, {24'd0, mdl_cmd});
                    chk("data_word", {16'd0, data_word}, {16'd0, mdl_data});
                end
            end
            prev_strobe = cmd_valid | frame_err;
        end
    end

    task automatic shift_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = bits[i];
            repeat (4) @(negedge sys_clk);
            miso_cap = {miso_cap[22:0], spi_miso};
            spi_sclk = 1'b1;
            repeat (4) @(negedge sys_clk);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] bits, input int n, input int gap);
        spi_cs_n = 1'b0;
        repeat (4) @(negedge sys_clk);
        shift_bits(bits, n);
        repeat (4) @(negedge sys_clk);
        spi_cs_n = 1'b1;
        repeat (gap) @(negedge sys_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int exp_valid;
        sys_rst  = 1'b1;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("reset_cmd_word", {24'd0, cmd_word}, 32'h0);
        chk("reset_data_word", {16'd0, data_word}, 32'h0);
        chk("reset_cmd_valid", {31'd0, cmd_valid}, 32'h0);
        chk("reset_frame_err", {31'd0, frame_err}, 32'h0);
        chk("reset_spi_miso", {31'd0, spi_miso}, 32'h0);
        sys_rst = 1'b0;
        repeat (6) @(negedge sys_clk);

        // Test 1: good frame and strobe latency after CS rise.
        exp_q.push_back('{1'b0, 8'h23, 16'h1234});
        send_frame(32'h0023_1234, 24, 0);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge sys_clk);
            if (cmd_valid && lat == 0) lat = k;
        end
        chk("valid_latency", lat, c_SYNC + 2);
        chk("t1_cmd_word", {24'd0, cmd_word}, 32'h23);
        chk("t1_data_word", {16'd0, data_word}, 32'h1234);

        // Test 2: short and long frames are rejected, outputs hold.
        exp_q.push_back('{1'b1, 8'h00, 16'h0000});
        send_frame(32'h0055_AAAA, 23, 8);
        exp_q.push_back('{1'b1, 8'h00, 16'h0000});
        send_frame(32'h01FF_0F0F, 25, 8);
        chk("t2_hold_cmd", {24'd0, cmd_word}, 32'h23);
        chk("t2_hold_data", {16'd0, data_word}, 32'h1234);

        // Test 3: reset mid-frame, remainder of frame ignored, next frame accepted.
        spi_cs_n = 1'b0;
        repeat (4) @(negedge sys_clk);
        shift_bits(32'h0000_03A5, 10);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("midrst_cmd_word", {24'd0, cmd_word}, 32'h0);
        chk("midrst_data_word", {16'd0, data_word}, 32'h0);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        shift_bits(32'h0000_3C3C, 14);
        repeat (4) @(negedge sys_clk);
        spi_cs_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        chk("t3_after_cmd", {24'd0, cmd_word}, 32'h0);
        chk("t3_after_data", {16'd0, data_word}, 32'h0);
        exp_q.push_back('{1'b0, 8'hA5, 16'hBEEF});
        send_frame(32'h00A5_BEEF, 24, 8);

        // Test 4: back-to-back frames with minimum CS-high gap.
        exp_q.push_back('{1'b0, 8'h01, 16'h0001});
        send_frame(32'h0001_0001, 24, 2);
        exp_q.push_back('{1'b0, 8'h80, 16'hFFFF});
        send_frame(32'h0080_FFFF, 24, 10);

        // Test 5: zero-bit frame, then SCLK activity with CS high.
        exp_q.push_back('{1'b1, 8'h00, 16'h0000});
        spi_cs_n = 1'b0;
        repeat (10) @(negedge sys_clk);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge sys_clk);
        for (int t = 0; t < 6; t++) begin
            spi_sclk = ~spi_sclk;
            spi_mosi = ~spi_mosi;
            repeat (4) @(negedge sys_clk);
            chk("miso_idle_zero", {31'd0, spi_miso}, 32'h0);
        end
        spi_sclk = 1'b0;
        repeat (10) @(negedge sys_clk);

        exp_valid = 4;
`ifdef SPI_CMD_ECHO_EN
        // Test 6: second frame reads back the first one on spi_miso.
        exp_q.push_back('{1'b0, 8'h23, 16'h1234});
        send_frame(32'h0023_1234, 24, 10);
        chk("miso_cs_high", {31'd0, spi_miso}, 32'h0);
        miso_cap = 24'h0;
        exp_q.push_back('{1'b0, 8'h00, 16'h0000});
        send_frame(32'h0000_0000, 24, 10);
        chk("echo_miso", {8'd0, miso_cap}, 32'h0023_1234);
        exp_valid = 6;
`endif

        repeat (10) @(negedge sys_clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("valid_count", n_valid_seen, exp_valid);
        chk("err_count", n_err_seen, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
